// File: rtl/dsdmnist_resultreader_if.sv
// Result-buffer read port plus classification record stream.
// master = reader (drives buffer address, produces records), slave = buffer/consumer side.
interface dsdmnist_resultreader_if #(
  parameter int IMGNUM = 10
);
  localparam int OAW = $clog2(IMGNUM * 10);
  localparam int IXW = (IMGNUM > 1) ? $clog2(IMGNUM) : 1;

  logic                  resultbuf_en;
  logic [OAW-1:0]        resultbuf_addr;
  logic [31:0]           resultbuf_data;
  logic                  cls_valid;
  logic                  cls_ready;
  logic [IXW-1:0]        cls_imgidx;
  logic [3:0]            cls_digit;
  logic [31:0]           cls_score;

  modport master (
    output resultbuf_en, resultbuf_addr,
    input  resultbuf_data,
    output cls_valid, cls_imgidx, cls_digit, cls_score,
    input  cls_ready
  );

  modport slave (
    input  resultbuf_en, resultbuf_addr,
    output resultbuf_data,
    input  cls_valid, cls_imgidx, cls_digit, cls_score,
    output cls_ready
  );
endinterface

// File: rtl/dsdmnist_resultreader.sv
// Reads IMGNUM*10 signed class scores from the result buffer, finds the
// argmax digit per image and emits one {image, digit, score} record each.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for i_START
// READ  | 11 cycles per image: 10 buffer reads, then one drain cycle
// EMIT  | record held on the stream until the consumer takes it
// DONE  | single-cycle o_DONE pulse, then back to IDLE
module dsdmnist_resultreader #(
  parameter int IMGNUM = 10
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_n,
  input  logic                    i_START,
  output logic                    o_BUSY,
  output logic                    o_DONE,
  dsdmnist_resultreader_if.master bus
);
  localparam int OAW = $clog2(IMGNUM * 10);
  localparam int IXW = (IMGNUM > 1) ? $clog2(IMGNUM) : 1;
  localparam logic [IXW-1:0] LAST_IMG = IXW'(IMGNUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EMIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cyc_q, cyc_d;
  logic [IXW-1:0]     img_q, img_d;
  logic               en_q, en_d;
  logic [OAW-1:0]     addr_q, addr_d;
  logic signed [31:0] max_q, max_d;
  logic [3:0]         arg_q, arg_d;
  logic               valid_q, valid_d;
  logic [IXW-1:0]     imgidx_q, imgidx_d;
  logic [3:0]         digit_q, digit_d;
  logic [31:0]        score_q, score_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic signed [31:0] samp;
  logic               take;
  logic signed [31:0] cand_max;
  logic [3:0]         cand_arg;

  // Next-state and output computation; the read pipeline is one cycle behind
  // the address, so digit k arrives when cyc_q == k+1.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    img_d    = img_q;
    en_d     = en_q;
    addr_d   = addr_q;
    max_d    = max_q;
    arg_d    = arg_q;
    valid_d  = valid_q;
    imgidx_d = imgidx_q;
    digit_d  = digit_q;
    score_d  = score_q;
    done_d   = 1'b0;

    samp     = $signed(bus.resultbuf_data);
    take     = (cyc_q == 4'd1) || (samp > max_q);
    cand_max = take ? samp : max_q;
    cand_arg = take ? (cyc_q - 4'd1) : arg_q;

    case (state_q)
      S_IDLE: begin
        if (i_START) begin
          state_d = S_READ;
          cyc_d   = 4'd0;
          img_d   = '0;
          en_d    = 1'b1;
          addr_d  = '0;
        end
      end
      S_READ: begin
        cyc_d = cyc_q + 4'd1;
        if (cyc_q >= 4'd1) begin
          max_d = cand_max;
          arg_d = cand_arg;
        end
        if (cyc_q < 4'd9) begin
          en_d   = 1'b1;
          addr_d = addr_q + 1'b1;
        end else begin
          en_d = 1'b0;
        end
        if (cyc_q == 4'd10) begin
          state_d  = S_EMIT;
          cyc_d    = 4'd0;
          valid_d  = 1'b1;
          imgidx_d = img_q;
          digit_d  = cand_arg;
          score_d  = cand_max;
        end
      end
      S_EMIT: begin
        if (bus.cls_ready) begin
          valid_d = 1'b0;
          if (img_q == LAST_IMG) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            // Address holds the previous image's last slot, so +1 is the next base.
            state_d = S_READ;
            img_d   = img_q + 1'b1;
            cyc_d   = 4'd0;
            en_d    = 1'b1;
            addr_d  = addr_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; async reset clears everything immediately.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      img_q    <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      max_q    <= '0;
      arg_q    <= '0;
      valid_q  <= 1'b0;
      imgidx_q <= '0;
      digit_q  <= '0;
      score_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      img_q    <= img_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
      max_q    <= max_d;
      arg_q    <= arg_d;
      valid_q  <= valid_d;
      imgidx_q <= imgidx_d;
      digit_q  <= digit_d;
      score_q  <= score_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_BUSY             = busy_q;
  assign o_DONE             = done_q;
  assign bus.resultbuf_en   = en_q;
  assign bus.resultbuf_addr = addr_q;
  assign bus.cls_valid      = valid_q;
  assign bus.cls_imgidx     = imgidx_q;
  assign bus.cls_digit      = digit_q;
  assign bus.cls_score      = score_q;
endmodule
